sbtm_recip_pipe: RTL and testbench

- Parametrised, pipelined symmetric-bipartite-table (SBTM) reciprocal approximation unit.
- Input is a normalised mantissa. Its fields address two runtime-loadable lookup tables (T0: coarse term, T1: symmetric correction term). The two table outputs are summed with ones-complement folding, and the top bits are returned.
- Sits ahead of the divider / Newton-Raphson iteration as the seed generator.
- Adds a valid/ready streaming interface, a tag passthrough, a carry-out flag and a table-load port.

---
 rtl/sbtm_recip_pipe.sv | 142 ++++++++++++++
 tb/tb_sbtm_recip_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbtm_recip_pipe.sv
// Symmetric-bipartite-table reciprocal seed generator.
// Three-stage pipeline: address decode, synchronous table read, fold-and-add.
// Both tables are runtime loadable and are never cleared by reset.
module sbtm_recip_pipe #(
    parameter int N0   = 4,
    parameter int N1   = 3,
    parameter int N2   = 4,
    parameter int Y0W  = 13,
    parameter int Y1W  = 5,
    parameter int OUTW = 11,
    parameter int TAGW = 4,
    localparam int AW  = ((N0 + N1) > (N0 + N2 - 1)) ? (N0 + N1) : (N0 + N2 - 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N0+N1+N2:0]     in_a,
    input  logic [TAGW-1:0]       in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUTW-1:0]       out_ia,
    output logic [TAGW-1:0]       out_tag,
    output logic                  out_cout,
    input  logic                  tbl_we,
    input  logic                  tbl_sel,
    input  logic [AW-1:0]         tbl_addr,
    input  logic [Y0W-1:0]        tbl_wdata
);

    localparam int A0W = N0 + N1;
    localparam int A1W = N0 + N2 - 1;
    localparam int SW  = Y0W + 2;

    // Fold the low field about its midpoint so T1 only stores half the entries.
    function automatic logic [N2-2:0] fold_x2(input logic [N2-1:0] x);
        return x[N2-1] ? ~x[N2-2:0] : x[N2-2:0];
    endfunction

    // Sum coarse and correction terms; a negative correction is the ones
    // complement of the shifted y1 with the upper bits sign-filled.
    // Returns {carry, sum} and wraps modulo 2^SW.
    function automatic logic [SW:0] sbtm_sum(input logic [Y0W-1:0] y0,
                                             input logic [Y1W-1:0] y1,
                                             input logic           s);
        logic [SW-1:0] op1;
        logic [SW-1:0] op2;
        op1 = {1'b0, y0, 1'b0};
        op2 = {{(SW-Y1W-1){s}}, y1 ^ {Y1W{s}}, 1'b1};
        return {1'b0, op1} + {1'b0, op2};
    endfunction

    logic                 adv;

    logic [A0W-1:0]       addr0_p0;
    logic [A1W-1:0]       addr1_p0;
    logic                 s_p0;
    logic [TAGW-1:0]      tag_p0;
    logic                 vld_p0;

    logic [Y0W-1:0]       y0_p1;
    logic [Y1W-1:0]       y1_p1;
    logic                 s_p1;
    logic [TAGW-1:0]      tag_p1;
    logic                 vld_p1;
    logic [SW:0]          sum_p1;

    logic [OUTW-1:0]      ia_p2;
    logic                 cout_p2;
    logic [TAGW-1:0]      tag_p2;
    logic                 vld_p2;

    logic [Y0W-1:0]       t0 [0:(1<<A0W)-1];
    logic [Y1W-1:0]       t1 [0:(1<<A1W)-1];

    logic [N2-1:0]        x2;
    logic                 unused_bits;

    // Whole pipe moves together; only a stalled valid output freezes it.
    assign adv       = !vld_p2 || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p2;
    assign out_ia    = ia_p2;
    assign out_cout  = cout_p2;
    assign out_tag   = tag_p2;

    assign x2          = in_a[N2-1:0];
    assign sum_p1      = sbtm_sum(y0_p1, y1_p1, s_p1);
    assign unused_bits = ^{in_a, tbl_wdata, tbl_addr, sum_p1};

    // Stage 1: split the mantissa into table addresses and capture the tag.
    always_ff @(posedge clk) begin
        if (adv) begin
            addr0_p0 <= in_a[N0+N1+N2-1 -: A0W];
            addr1_p0 <= {in_a[N0+N1+N2-1 -: N0], fold_x2(x2)};
            s_p0     <= x2[N2-1];
            tag_p0   <= in_tag;
        end
        if (reset)    vld_p0 <= 1'b0;
        else if (adv) vld_p0 <= in_valid;
    end

    // Stage 2: T0 write port and read-first registered read.
    always_ff @(posedge clk) begin
        if (tbl_we && !tbl_sel) t0[tbl_addr[A0W-1:0]] <= tbl_wdata;
        if (adv)                y0_p1 <= t0[addr0_p0];
    end

    // Stage 2: T1 write port and read-first registered read.
    always_ff @(posedge clk) begin
        if (tbl_we && tbl_sel) t1[tbl_addr[A1W-1:0]] <= tbl_wdata[Y1W-1:0];
        if (adv)               y1_p1 <= t1[addr1_p0];
    end

    // Stage 2: sign and tag follow the table data.
    always_ff @(posedge clk) begin
        if (adv) begin
            s_p1   <= s_p0;
            tag_p1 <= tag_p0;
        end
        if (reset)    vld_p1 <= 1'b0;
        else if (adv) vld_p1 <= vld_p0;
    end

    // Stage 3: register the truncated sum; outputs only change on a real result.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p2  <= 1'b0;
            ia_p2   <= '0;
            cout_p2 <= 1'b0;
            tag_p2  <= '0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                ia_p2   <= sum_p1[SW-1 -: OUTW];
                cout_p2 <= sum_p1[SW];
                tag_p2  <= tag_p1;
            end
        end
    end

endmodule

// File: tb/tb_sbtm_recip_pipe.sv
// Directed bench for sbtm_recip_pipe: table-driven single operands plus
// streaming, back-pressure, write-collision and mid-stream reset sequences.
module tb_sbtm_recip_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_a;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_ia;
    logic [3:0]  out_tag;
    logic        out_cout;
    logic        tbl_we;
    logic        tbl_sel;
    logic [6:0]  tbl_addr;
    logic [12:0] tbl_wdata;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [11:0] a;
        logic [6:0]  a0;
        logic [12:0] d0;
        logic [6:0]  a1;
        logic [4:0]  d1;
        logic [10:0] ia;
        logic        cout;
    } vec_t;

    vec_t vecs [6];

    sbtm_recip_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ia    (out_ia),
        .out_tag   (out_tag),
        .out_cout  (out_cout),
        .tbl_we    (tbl_we),
        .tbl_sel   (tbl_sel),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called right after a negedge; returns right after the next negedge.
    task automatic write_tbl(input logic sel, input logic [6:0] addr, input logic [12:0] data);
        tbl_we    = 1'b1;
        tbl_sel   = sel;
        tbl_addr  = addr;
        tbl_wdata = data;
        @(negedge clk);
        tbl_we    = 1'b0;
    endtask

    // Send one operand into an idle pipe and measure edges until out_valid.
    task automatic send_one(input logic [11:0] a, input logic [3:0] tag,
                            output logic [10:0] ia, output logic cout,
                            output logic [3:0] tg, output int lat);
        in_valid  = 1'b1;
        in_a      = a;
        in_tag    = tag;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        ia   = out_ia;
        cout = out_cout;
        tg   = out_tag;
        @(negedge clk);
    endtask

    // Operand k uses x1 = k with T0[k] = k<<6 and T1[0] = 0, so out_ia = 8*k.
    task automatic run_stream(input int n, input int stall, input logic [3:0] tag_base);
        int tx;
        int rx;
        int first_rx;
        int last_rx;
        tx = 0;
        rx = 0;
        first_rx = -1;
        last_rx  = -1;
        for (int cyc = 0; cyc < 40 && rx < n; cyc++) begin
            out_ready = (cyc >= stall);
            in_valid  = (tx < n);
            in_a      = 12'h800 | 12'(tx << 4);
            in_tag    = tag_base + 4'(tx);
            #1;
            if (stall > 0 && cyc == stall - 1) begin
                check("stall_accepts", tx, 3);
                check("stall_in_ready", {31'd0, in_ready}, 0);
            end
            if (out_valid) begin
                check("stream_ia", {21'd0, out_ia}, 32'(rx * 8));
                check("stream_tag", {28'd0, out_tag}, {28'd0, 4'(tag_base + 4'(rx))});
                if (out_ready) begin
                    if (first_rx < 0) first_rx = cyc;
                    last_rx = cyc;
                    rx++;
                end
            end
            if (in_valid && in_ready) tx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream_sent", tx, n);
        check("stream_count", rx, n);
        if (stall == 0) check("stream_spacing", last_rx - first_rx, n - 1);
    endtask

    logic [10:0] r_ia;
    logic        r_cout;
    logic [3:0]  r_tag;
    int          r_lat;
    int          rx;
    int          stale;

    initial begin
        vecs[0] = '{12'h800, 7'h00, 13'h1FFF, 7'h00, 5'h1F, 11'h403, 1'b0};
        vecs[1] = '{12'h808, 7'h00, 13'h1000, 7'h07, 5'h01, 11'h1FF, 1'b1};
        vecs[2] = '{12'hFFF, 7'h7F, 13'h0ABC, 7'h78, 5'h0A, 11'h156, 1'b1};
        vecs[3] = '{12'h123, 7'h12, 13'h1234, 7'h13, 5'h11, 11'h248, 1'b0};
        vecs[4] = '{12'hC55, 7'h45, 13'h0000, 7'h45, 5'h1F, 11'h003, 1'b0};
        vecs[5] = '{12'h80F, 7'h00, 13'h0000, 7'h00, 5'h00, 11'h7FF, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        tbl_we    = 1'b0;
        tbl_sel   = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;

        repeat (2) @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 0);
        check("reset_out_ia", {21'd0, out_ia}, 0);
        check("reset_out_tag", {28'd0, out_tag}, 0);
        check("reset_out_cout", {31'd0, out_cout}, 0);
        check("reset_in_ready", {31'd0, in_ready}, 1);
        reset = 1'b0;

        // Single operands against freshly loaded entries.
        for (int i = 0; i < 6; i++) begin
            write_tbl(1'b0, vecs[i].a0, vecs[i].d0);
            write_tbl(1'b1, vecs[i].a1, {8'd0, vecs[i].d1});
            send_one(vecs[i].a, 4'(i + 1), r_ia, r_cout, r_tag, r_lat);
            check("vec_ia", {21'd0, r_ia}, {21'd0, vecs[i].ia});
            check("vec_cout", {31'd0, r_cout}, {31'd0, vecs[i].cout});
            check("vec_tag", {28'd0, r_tag}, 32'(i + 1));
            check("vec_latency", r_lat, 3);
        end

        // Back-to-back stream, then a stalled stream.
        for (int k = 0; k < 8; k++) write_tbl(1'b0, 7'(k), 13'(k << 6));
        write_tbl(1'b1, 7'h00, 13'h0000);
        run_stream(8, 0, 4'h8);
        run_stream(5, 8, 4'h1);

        // T1[0] rewritten on the very edge the first operand reads it.
        write_tbl(1'b0, 7'h00, 13'h1FFF);
        write_tbl(1'b1, 7'h00, 13'h001F);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 12'h800;
        in_tag    = 4'd5;
        @(negedge clk);
        in_tag    = 4'd6;
        tbl_we    = 1'b1;
        tbl_sel   = 1'b1;
        tbl_addr  = 7'h00;
        tbl_wdata = 13'h0000;
        @(negedge clk);
        in_valid = 1'b0;
        tbl_we   = 1'b0;
        rx = 0;
        for (int c = 0; c < 10 && rx < 2; c++) begin
            if (out_valid) begin
                if (rx == 0) begin
                    check("wr_old_ia", {21'd0, out_ia}, 32'h403);
                    check("wr_old_tag", {28'd0, out_tag}, 5);
                end else begin
                    check("wr_new_ia", {21'd0, out_ia}, 32'h3FF);
                    check("wr_new_tag", {28'd0, out_tag}, 6);
                end
                rx++;
            end
            @(negedge clk);
        end
        check("wr_count", rx, 2);

        // Three operands in flight, output stalled, then a one-cycle reset
        // that also writes T0[4].
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1;
            in_a     = 12'h800 | 12'(k << 4);
            in_tag   = 4'(k);
            #1;
            check("rst_fill_ready", {31'd0, in_ready}, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("rst_pre_valid", {31'd0, out_valid}, 1);
        reset     = 1'b1;
        tbl_we    = 1'b1;
        tbl_sel   = 1'b0;
        tbl_addr  = 7'h04;
        tbl_wdata = 13'(5 << 6);
        @(negedge clk);
        reset  = 1'b0;
        tbl_we = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_ia", {21'd0, out_ia}, 0);
        check("rst_out_tag", {28'd0, out_tag}, 0);
        check("rst_out_cout", {31'd0, out_cout}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) stale++;
            @(negedge clk);
        end
        check("rst_no_stale", stale, 0);
        send_one(12'h820, 4'd9, r_ia, r_cout, r_tag, r_lat);
        check("rst_retained_ia", {21'd0, r_ia}, 32'h010);
        check("rst_retained_tag", {28'd0, r_tag}, 9);
        check("rst_retained_lat", r_lat, 3);
        send_one(12'h840, 4'd10, r_ia, r_cout, r_tag, r_lat);
        check("rst_write_ia", {21'd0, r_ia}, 32'h028);
        check("rst_write_tag", {28'd0, r_tag}, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
